// File: rtl/muxn_skid.sv
// N-way BITS-wide selector with a registered output stage and a 2-entry skid buffer.
// Illegal select codes fall back to channel 0 and raise a sticky error flag.
module muxn_skid #(
    parameter int BITS = 16,
    parameter int N    = 3,
    parameter int SELW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SELW-1:0]   sel,
    input  logic [N*BITS-1:0] in_bus,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BITS-1:0]   out_data,
    output logic              sel_err,
    input  logic              err_clr
);

    logic [BITS-1:0] r_out_data;
    logic            r_out_valid;
    logic [BITS-1:0] r_skid_data;
    logic            r_skid_v;
    logic            r_in_ready;
    logic            r_sel_err;

    logic [BITS-1:0] w_chosen;
    logic            w_illegal;
    logic            w_accept;
    logic            w_drain;

    // Codes with no matching channel keep the channel-0 default and flag illegal.
    always_comb begin
        w_chosen  = in_bus[BITS-1:0];
        w_illegal = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (sel == SELW'(k)) begin
                w_chosen  = in_bus[k*BITS +: BITS];
                w_illegal = 1'b0;
            end
        end
    end

    assign w_accept = in_valid & r_in_ready;
    assign w_drain  = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_skid_data <= '0;
            r_skid_v    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_sel_err   <= 1'b0;
        end else begin
            if (w_accept && w_illegal) begin
                r_sel_err <= 1'b1;
            end else if (err_clr) begin
                r_sel_err <= 1'b0;
            end

            if (flush) begin
                r_out_valid <= 1'b0;
                r_skid_v    <= 1'b0;
                r_in_ready  <= 1'b1;
            end else if (r_skid_v) begin
                // in_ready is low here, so only a drain can move state.
                if (w_drain) begin
                    r_out_data <= r_skid_data;
                    r_skid_v   <= 1'b0;
                    r_in_ready <= 1'b1;
                end
            end else if (!r_out_valid || w_drain) begin
                if (w_accept) begin
                    r_out_data  <= w_chosen;
                    r_out_valid <= 1'b1;
                end else begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_data <= w_chosen;
                r_skid_v    <= 1'b1;
                r_in_ready  <= 1'b0;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign sel_err   = r_sel_err;

endmodule

// File: tb/tb_muxn_skid.sv
// Bench for muxn_skid: directed scenarios on a 16-bit 3-way instance and a
// randomized run on an 8-bit 4-way instance, both checked against a queue model.
module tb_muxn_skid;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: BITS=16, N=3, SELW=2
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready, sel_err, err_clr;
    logic [1:0]  sel;
    logic [47:0] in_bus;
    logic [15:0] out_data;

    // Instance B: BITS=8, N=4, SELW=2
    logic        b_rst, b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_sel_err, b_err_clr;
    logic [1:0]  b_sel;
    logic [31:0] b_in_bus;
    logic [7:0]  b_out_data;

    muxn_skid #(.BITS(16), .N(3), .SELW(2)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .in_bus(in_bus), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .sel_err(sel_err), .err_clr(err_clr)
    );

    muxn_skid #(.BITS(8), .N(4), .SELW(2)) dut_b (
        .clk(clk), .rst(b_rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel), .in_bus(b_in_bus), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .sel_err(b_sel_err), .err_clr(b_err_clr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Scoreboard model for instance A: queue of held entries (main first).
    logic [15:0] q_a[$];
    logic        m_ready;
    logic        m_err;
    logic [15:0] m_data;

    // One clock for instance A: pushes accepted data, pops drained data.
    task automatic tick();
        logic        acc, drn;
        logic [15:0] ch;
        ch  = (int'(sel) < 3) ? in_bus[int'(sel)*16 +: 16] : in_bus[15:0];
        acc = in_valid && m_ready;
        drn = (q_a.size() > 0) && out_ready;
        @(posedge clk);
        if (rst) begin
            q_a.delete();
            m_ready = 1'b1;
            m_err   = 1'b0;
            m_data  = 16'h0;
        end else begin
            if (acc && int'(sel) >= 3) m_err = 1'b1;
            else if (err_clr)          m_err = 1'b0;
            if (flush) begin
                q_a.delete();
                m_ready = 1'b1;
            end else begin
                if (drn) void'(q_a.pop_front());
                if (acc) q_a.push_back(ch);
                m_ready = (q_a.size() < 2);
                if (q_a.size() > 0) m_data = q_a[0];
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; sel = 2'd1; in_bus = {16'h3333, 16'h2222, 16'h1111};
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_tests++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0000", out_data); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL reset_sel_err got=%b exp=0", sel_err); end
    endtask

    task automatic test_stream();
        logic [15:0] exp_v[3];
        exp_v[0] = 16'h1111; exp_v[1] = 16'h2222; exp_v[2] = 16'h3333;
        in_bus = {16'h3333, 16'h2222, 16'h1111};
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            tick();
            n_tests++; if (out_valid !== 1'b1 || out_data !== exp_v[i]) begin n_fail++; $display("FAIL stream%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, exp_v[i]); end
            n_tests++; if (q_a.size() == 0 || out_data !== q_a[0]) begin n_fail++; $display("FAIL stream%0d_sb got=%h exp=%h", i, out_data, m_data); end
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream%0d_ready got=%b exp=1", i, in_ready); end
        end
        in_valid = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        in_bus = {16'hCCCC, 16'hBBBB, 16'hAAAA};
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        tick();
        n_tests++; if (out_data !== 16'hAAAA || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first got v=%b d=%h exp v=1 d=aaaa", out_valid, out_data); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready1 got=%b exp=1", in_ready); end
        sel = 2'd1;
        tick();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready0 got=%b exp=0", in_ready); end
        // Offered entry while full must not be accepted.
        sel = 2'd2;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_tests++; if (out_data !== 16'hAAAA || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d got v=%b d=%h exp v=1 d=aaaa", i, out_valid, out_data); end
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready%0d got=%b exp=0", i, in_ready); end
        end
        out_ready = 1'b1;
        tick();
        n_tests++; if (out_data !== 16'hBBBB || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second got v=%b d=%h exp v=1 d=bbbb", out_valid, out_data); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_back got=%b exp=1", in_ready); end
        in_valid = 1'b0;
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b exp=0 (sb size %0d)", out_valid, q_a.size()); end
    endtask

    task automatic test_illegal();
        in_bus = {16'h3333, 16'h2222, 16'h0F0F};
        out_ready = 1'b1; in_valid = 1'b0; sel = 2'd3;
        tick();
        n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL illegal_noaccept got=%b exp=0", sel_err); end
        in_valid = 1'b1;
        tick();
        n_tests++; if (out_data !== 16'h0F0F || out_valid !== 1'b1) begin n_fail++; $display("FAIL illegal_data got v=%b d=%h exp v=1 d=0f0f", out_valid, out_data); end
        n_tests++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL illegal_set got=%b exp=1", sel_err); end
        in_valid = 1'b0;
        tick();
        n_tests++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky got=%b exp=1", sel_err); end
        in_valid = 1'b1; err_clr = 1'b1;
        tick();
        n_tests++; if (sel_err !== 1'b1) begin n_fail++; $display("FAIL illegal_set_wins got=%b exp=1", sel_err); end
        in_valid = 1'b0;
        tick();
        err_clr = 1'b0;
        n_tests++; if (sel_err !== 1'b0) begin n_fail++; $display("FAIL illegal_clear got=%b exp=0", sel_err); end
        n_tests++; if (sel_err !== m_err) begin n_fail++; $display("FAIL illegal_model got=%b exp=%b", sel_err, m_err); end
        tick();
    endtask

    task automatic test_flush();
        in_bus = {16'h9999, 16'h5678, 16'h1234};
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        tick();
        sel = 2'd1;
        tick();
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full got=%b exp=0", in_ready); end
        flush = 1'b1; sel = 2'd2;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_state got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ghost%0d got=%b exp=0", i, out_valid); end
        end
        // Accept in the flush cycle with the buffer empty is discarded too.
        in_valid = 1'b1; flush = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b0;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_accept got=%b exp=0", out_valid); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_accept_after got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        in_bus = {16'h7777, 16'h6666, 16'h5555};
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3;
        tick();
        sel = 2'd1;
        tick();
        n_tests++; if (in_ready !== 1'b0 || sel_err !== 1'b1 || out_data !== 16'h5555) begin n_fail++; $display("FAIL rstmid_setup got r=%b e=%b d=%h exp r=0 e=1 d=5555", in_ready, sel_err, out_data); end
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || out_data !== 16'h0) begin n_fail++; $display("FAIL rstmid_out got v=%b d=%h exp v=0 d=0000", out_valid, out_data); end
        n_tests++; if (in_ready !== 1'b1 || sel_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl got r=%b e=%b exp r=1 e=0", in_ready, sel_err); end
        tick();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_nothing got=%b exp=0", out_valid); end
    endtask

    task automatic test_sweep();
        logic [7:0] bq[$];
        logic       br, acc, drn, stall;
        logic [7:0] ch, held;
        br = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0;
            if (c % 200 < 40) b_out_ready = 1'b0;
            b_sel    = 2'($urandom_range(0, 3));
            b_in_bus = $urandom;
            ch    = b_in_bus[int'(b_sel)*8 +: 8];
            acc   = b_in_valid && br;
            drn   = (bq.size() > 0) && b_out_ready;
            stall = (bq.size() > 0) && !b_out_ready;
            held  = (bq.size() > 0) ? bq[0] : 8'h0;
            @(posedge clk);
            if (drn) void'(bq.pop_front());
            if (acc) bq.push_back(ch);
            br = (bq.size() < 2);
            #1;
            n_tests++; if (b_out_valid !== (bq.size() > 0)) begin n_fail++; $display("FAIL sweep_valid c=%0d got=%b exp=%b", c, b_out_valid, (bq.size() > 0)); end
            n_tests++; if (b_in_ready !== br) begin n_fail++; $display("FAIL sweep_ready c=%0d got=%b exp=%b", c, b_in_ready, br); end
            if (bq.size() > 0) begin
                n_tests++; if (b_out_data !== bq[0]) begin n_fail++; $display("FAIL sweep_data c=%0d got=%h exp=%h", c, b_out_data, bq[0]); end
            end
            if (stall) begin
                n_tests++; if (b_out_data !== held) begin n_fail++; $display("FAIL sweep_stable c=%0d got=%h exp=%h", c, b_out_data, held); end
            end
            n_tests++; if (b_sel_err !== 1'b0) begin n_fail++; $display("FAIL sweep_sel_err c=%0d got=%b exp=0", c, b_sel_err); end
        end
        b_in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        sel = 2'd0; in_bus = '0;
        b_rst = 1'b1; b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_err_clr = 1'b0;
        b_sel = 2'd0; b_in_bus = '0;
        m_ready = 1'b1; m_err = 1'b0; m_data = 16'h0;
        #1;
        test_reset();
        b_rst = 1'b0;
        test_stream();
        test_backpressure();
        test_illegal();
        test_flush();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/muxn_skid.md
Name: muxn_skid

Overview:
- Parametrised N-way, BITS-wide selector with a registered output stage and a 2-entry skid buffer under a valid/ready handshake.
- It generalises the team's fixed 3:1 combinational selector for pipeline boundaries in the 16-bit MIPS datapath, such as the forwarding and writeback-source selection feeding the next stage.
- It tolerates downstream backpressure without losing data.
- It flags select codes outside the legal range.

Parameters:
- BITS, 16, data width of each input and of the output.
- N, 3, number of input channels (2..16).
- SELW, 2, select width; must satisfy 2**SELW >= N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- flush  input  1  synchronous pipeline flush; discards all buffered entries.
- in_valid  input  1  upstream presents sel/in_bus this cycle.
- in_ready  output  1  block can accept an entry this cycle (registered).
- sel  input  SELW  channel select, sampled on accept.
- in_bus  input  N*BITS  flattened inputs; channel k is in_bus[k*BITS +: BITS].
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  downstream consumes the entry when out_valid is high.
- out_data  output  BITS  selected data (registered).
- sel_err  output  1  sticky flag: an illegal select was accepted.
- err_clr  input  1  clears sel_err.

Behaviour:
- Selection rules:
  - Selection is combinational on input: chosen = channel sel if sel < N, else channel 0.
  - Only the chosen value is stored; sel is not stored.
- Accept and drain events:
  - Accept = in_valid & in_ready.
  - Drain = out_valid & out_ready.
- State:
  - main entry: out_data with valid bit out_valid.
  - skid entry: skid_data with valid bit skid_v.
  - in_ready = ~skid_v, registered as a flop.
- Reset (rst=1 at a clock edge, dominates all other inputs):
  - out_valid=0, out_data=0, skid_v=0, skid_data=0, in_ready=1, sel_err=0.
  - Reset mid-transfer discards all entries.
- Latency and throughput:
  - An accepted entry appears on out_data/out_valid the cycle after accept when main is empty or draining.
  - Throughput is 1 per cycle while out_ready=1.
- Transitions per edge, when not in reset and not flushing:
  - main empty, accept: main <= chosen.
  - main full, drain, no accept, skid_v=0: out_valid <= 0.
  - main full, drain, accept, skid_v=0: main <= chosen (back-to-back).
  - main full, no drain, accept: skid <= chosen, skid_v <= 1, in_ready <= 0.
  - skid_v=1, drain: main <= skid, skid_v <= 0, in_ready <= 1. No accept is possible this cycle because in_ready=0.
  - main full, no drain, no accept: hold everything. out_data must stay stable while out_valid & ~out_ready.
- Ordering:
  - Entries exit in acceptance order.
  - Never drop, never duplicate.
- flush=1 (no reset):
  - Next state: out_valid=0, skid_v=0, in_ready=1.
  - An entry accepted in the flush cycle is discarded.
  - out_data may hold a stale value.
  - sel_err is unaffected.
- sel_err:
  - Set on the edge after an accept with sel >= N.
  - Cleared by err_clr.
  - If set and clear occur in the same cycle, set wins.
  - Not set by sel values when in_valid=0 or in_ready=0.
- When N = 2**SELW, no illegal code exists and sel_err stays 0.
- Width rule: the output is exactly BITS wide, with no sign extension or truncation.

Test Plan:
- Reset then streaming:
  - Stimulus: rst 1 cycle; then in_valid=1, out_ready=1, sel=0,1,2 with channels 0x1111/0x2222/0x3333.
  - Required: out_data = 0x1111, 0x2222, 0x3333 on consecutive cycles, each 1 cycle after accept; in_ready stays 1.
- Backpressure:
  - Stimulus: out_ready=0 while sending 0xAAAA then 0xBBBB.
  - Required: out_data holds 0xAAAA, skid holds 0xBBBB, in_ready=0 from the next cycle.
  - Then raise out_ready: required 0xAAAA, 0xBBBB in order, and in_ready returns to 1 one cycle after the first drain.
- Illegal select:
  - Stimulus: N=3, accept sel=3 with channel 0 = 0x0F0F.
  - Required: out_data=0x0F0F, sel_err=1 next cycle and stays 1.
  - Then err_clr and an illegal accept in the same cycle: required sel_err remains 1; err_clr alone clears it to 0.
- Flush:
  - Stimulus: main and skid both full, flush=1 with in_valid=1 in the same cycle.
  - Required: next cycle out_valid=0, in_ready=1, and no entry appears afterwards.
- Reset mid-stall:
  - Stimulus: rst=1 with main and skid full and sel_err=1.
  - Required: next cycle out_valid=0, out_data=0, in_ready=1, sel_err=0.
- Parameter sweep:
  - Stimulus: BITS=8, N=4, SELW=2, random valid/ready over 1000 cycles.
  - Required: scoreboard order matches, sel_err never set, and out_data is stable while stalled.
